// File: rtl/lcd_cursor_sequencer.sv
// Keypad-to-LCD sequencer: runs the HD44780 power-up init, then turns each popped key
// into zero to three LCD ops while tracking the cursor on a COLS x ROWS panel.
module lcd_cursor_sequencer #(
    parameter int unsigned COLS      = 16,
    parameter int unsigned ROWS      = 2,
    parameter logic [7:0]  CLEAR_KEY = 8'h2A,
    parameter logic [7:0]  BKSP_KEY  = 8'h23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    input  logic       lcd_ready,
    output logic       lcd_start,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       init_done,
    output logic       busy,
    output logic       cursor_row,
    output logic [3:0] cursor_col
);

    localparam int unsigned COL_W    = 4;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    // S_ISSUE doubles as the init entry point; init_done selects the op source
    localparam logic [2:0] S_ISSUE   = 3'd0;
    localparam logic [2:0] S_WAIT_LO = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_IDLE    = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;
    localparam logic [2:0] S_POP     = 3'd5;
    localparam logic [2:0] S_DECODE  = 3'd6;

    logic [2:0]       state, state_next;
    logic [7:0]       key_reg, key_next;
    logic [7:0]       op_d0, op_d1, op_d2, op_d0_next, op_d1_next, op_d2_next;
    logic [2:0]       op_rs, op_rs_next;
    logic [1:0]       op_last, op_last_next;
    logic [1:0]       op_idx, op_idx_next;
    logic             rd_en_next, start_next, rs_next, init_done_next, row_next;
    logic [7:0]       data_next;
    logic [COL_W-1:0] col_next;

    logic [7:0]       init_cmd, cur_data, addr_cmd;
    logic             cur_rs;
    logic [1:0]       last_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_ISSUE;
            key_reg    <= 8'h00;
            op_d0      <= 8'h00;
            op_d1      <= 8'h00;
            op_d2      <= 8'h00;
            op_rs      <= 3'b000;
            op_last    <= 2'd0;
            op_idx     <= 2'd0;
            fifo_rd_en <= 1'b0;
            lcd_start  <= 1'b0;
            lcd_data   <= 8'h00;
            lcd_rs     <= 1'b0;
            init_done  <= 1'b0;
            busy       <= 1'b0;
            cursor_row <= 1'b0;
            cursor_col <= '0;
        end else begin
            state      <= state_next;
            key_reg    <= key_next;
            op_d0      <= op_d0_next;
            op_d1      <= op_d1_next;
            op_d2      <= op_d2_next;
            op_rs      <= op_rs_next;
            op_last    <= op_last_next;
            op_idx     <= op_idx_next;
            fifo_rd_en <= rd_en_next;
            lcd_start  <= start_next;
            lcd_data   <= data_next;
            lcd_rs     <= rs_next;
            init_done  <= init_done_next;
            busy       <= (state_next != S_IDLE);
            cursor_row <= row_next;
            cursor_col <= col_next;
        end
    end

    // Current op: fixed init table until init_done, then the decoded op list
    always_comb begin
        init_cmd = 8'h06;
        cur_data = op_d2;
        cur_rs   = op_rs[2];
        case (op_idx)
            2'd0: begin init_cmd = 8'h38; cur_data = op_d0; cur_rs = op_rs[0]; end
            2'd1: begin init_cmd = 8'h0C; cur_data = op_d1; cur_rs = op_rs[1]; end
            2'd2: init_cmd = 8'h01;
            default: ;
        endcase
        if (!init_done) begin
            cur_data = init_cmd;
            cur_rs   = 1'b0;
        end
        last_idx = init_done ? op_last : 2'd3;
    end

    always_comb begin
        state_next     = state;
        key_next       = key_reg;
        op_d0_next     = op_d0;
        op_d1_next     = op_d1;
        op_d2_next     = op_d2;
        op_rs_next     = op_rs;
        op_last_next   = op_last;
        op_idx_next    = op_idx;
        rd_en_next     = 1'b0;
        start_next     = 1'b0;
        data_next      = lcd_data;
        rs_next        = lcd_rs;
        init_done_next = init_done;
        row_next       = cursor_row;
        col_next       = cursor_col;
        addr_cmd       = 8'h80;

        case (state)
            S_ISSUE: begin
                if (lcd_ready) begin
                    start_next = 1'b1;
                    data_next  = cur_data;
                    rs_next    = cur_rs;
                    state_next = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!lcd_ready) state_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (lcd_ready) begin
                    if (op_idx == last_idx) begin
                        init_done_next = 1'b1;
                        op_idx_next    = 2'd0;
                        state_next     = S_IDLE;
                    end else begin
                        op_idx_next = op_idx + 2'd1;
                        state_next  = S_ISSUE;
                    end
                end
            end
            S_IDLE: begin
                if (!fifo_empty && init_done) begin
                    rd_en_next = 1'b1;
                    state_next = S_READ;
                end
            end
            S_READ:  state_next = S_POP;
            S_POP: begin
                key_next   = fifo_dout;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                op_idx_next = 2'd0;
                state_next  = S_ISSUE;
                if (key_reg == CLEAR_KEY) begin
                    op_d0_next   = 8'h01;
                    op_rs_next   = 3'b000;
                    op_last_next = 2'd0;
                    row_next     = 1'b0;
                    col_next     = '0;
                end else if (key_reg == BKSP_KEY) begin
                    if (!cursor_row && cursor_col == '0) begin
                        state_next = S_IDLE;
                    end else begin
                        if (cursor_col != '0) begin
                            col_next = cursor_col - COL_W'(1);
                        end else begin
                            row_next = 1'b0;
                            col_next = LAST_COL;
                        end
                        addr_cmd     = {1'b1, row_next, 2'b00, col_next};
                        op_d0_next   = addr_cmd;
                        op_d1_next   = 8'h20;
                        op_d2_next   = addr_cmd;
                        op_rs_next   = 3'b010;
                        op_last_next = 2'd2;
                    end
                end else if (key_reg >= 8'h20 && key_reg <= 8'h7E) begin
                    op_d0_next = key_reg;
                    op_rs_next = 3'b001;
                    if (cursor_col < LAST_COL) begin
                        col_next     = cursor_col + COL_W'(1);
                        op_last_next = 2'd0;
                    end else begin
                        // Last column: wrap to the next line (last line wraps to line 0)
                        col_next     = '0;
                        row_next     = (ROWS > 1) ? ~cursor_row : 1'b0;
                        op_d1_next   = {1'b1, row_next, 6'b000000};
                        op_last_next = 2'd1;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_ISSUE;
        endcase
    end

endmodule

// File: tb/tb_lcd_cursor_sequencer.sv
// Directed bench for lcd_cursor_sequencer: FIFO and lcd_wrapper models, op log, hand-computed expectations.
module tb_lcd_cursor_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en;
    logic       lcd_ready = 1'b1;
    logic       lcd_start;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       init_done;
    logic       busy;
    logic       cursor_row;
    logic [3:0] cursor_col;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fifo_mem [0:255];
    int         push_cnt = 0;
    int         pop_cnt  = 0;
    int         lcd_cnt  = 0;

    logic [7:0] log_data [0:511];
    logic       log_rs   [0:511];
    int         n_start = 0;
    int         n_rd    = 0;

    lcd_cursor_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .lcd_ready  (lcd_ready),
        .lcd_start  (lcd_start),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .init_done  (init_done),
        .busy       (busy),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (push_cnt == pop_cnt);

    // FIFO: data appears the cycle after the pop request
    always @(posedge clk) begin
        if (fifo_rd_en && push_cnt != pop_cnt) begin
            fifo_dout <= fifo_mem[pop_cnt % 256];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    // lcd_wrapper: drops ready for 5 cycles after each start
    always @(posedge clk) begin
        if (lcd_start) begin
            lcd_ready <= 1'b0;
            lcd_cnt   <= 5;
        end else if (lcd_cnt > 0) begin
            lcd_cnt <= lcd_cnt - 1;
            if (lcd_cnt == 1) lcd_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (lcd_start && n_start < 512) begin
            log_data[n_start] = lcd_data;
            log_rs[n_start]   = lcd_rs;
        end
        if (lcd_start) n_start = n_start + 1;
        if (fifo_rd_en) n_rd = n_rd + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_op(input string tag, input int idx, input logic [7:0] d, input logic rs);
        check({tag, " data"}, 32'(log_data[idx % 512]), 32'(d));
        check({tag, " rs"},   32'(log_rs[idx % 512]),   32'(rs));
    endtask

    task automatic push(input logic [7:0] d);
        fifo_mem[push_cnt % 256] = d;
        push_cnt++;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int t = 0;
        while (quiet < 4 && t < 4000) begin
            @(negedge clk);
            t++;
            if (!busy && fifo_empty) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) check({tag, " idle timeout"}, 32'(quiet), 32'd4);
    endtask

    task automatic wait_init(input string tag);
        int t = 0;
        while (!init_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!init_done) check({tag, " init timeout"}, 32'(init_done), 32'd1);
    endtask

    task automatic check_cursor(input string tag, input logic row, input logic [3:0] col);
        check({tag, " row"}, 32'(cursor_row), 32'(row));
        check({tag, " col"}, 32'(cursor_col), 32'(col));
    endtask

    task automatic check_init(input string tag, input int base);
        check({tag, " op count"}, 32'(n_start - base), 32'd4);
        check_op({tag, " op0"}, base,     8'h38, 1'b0);
        check_op({tag, " op1"}, base + 1, 8'h0C, 1'b0);
        check_op({tag, " op2"}, base + 2, 8'h01, 1'b0);
        check_op({tag, " op3"}, base + 3, 8'h06, 1'b0);
    endtask

    initial begin
        int base;
        int rd0;
        int t;

        // 1: reset state, then init sequence
        repeat (3) @(negedge clk);
        check("reset outs", 32'({fifo_rd_en, lcd_start, lcd_data, lcd_rs, init_done,
                                 busy, cursor_row, cursor_col}), 32'd0);
        rst = 1'b1;
        wait_init("t1");
        check_init("t1", 0);
        check("t1 rd during init", 32'(n_rd), 32'd0);
        wait_idle("t1");
        check("t1 init_done", 32'(init_done), 32'd1);
        check("t1 busy", 32'(busy), 32'd0);

        // 2: single printable key
        base = n_start; rd0 = n_rd;
        push(8'h41);
        wait_idle("t2");
        check("t2 rd pulses", 32'(n_rd - rd0), 32'd1);
        check("t2 op count", 32'(n_start - base), 32'd1);
        check_op("t2 op0", base, 8'h41, 1'b1);
        check_cursor("t2", 1'b0, 4'd1);

        // 3: clear, then a full line with wrap to line 1
        base = n_start;
        push(8'h2A);
        wait_idle("t3a");
        check("t3 clear count", 32'(n_start - base), 32'd1);
        check_op("t3 clear", base, 8'h01, 1'b0);
        check_cursor("t3 clear", 1'b0, 4'd0);
        base = n_start;
        for (int i = 0; i < 16; i++) push(8'h30);
        wait_idle("t3b");
        check("t3 op count", 32'(n_start - base), 32'd17);
        for (int i = 0; i < 16; i++) check_op($sformatf("t3 wr%0d", i), base + i, 8'h30, 1'b1);
        check_op("t3 wrap addr", base + 16, 8'hC0, 1'b0);
        check_cursor("t3", 1'b1, 4'd0);

        // backspace from the start of line 1 back to the end of line 0
        base = n_start;
        push(8'h23);
        wait_idle("t3c");
        check("t3 bksp count", 32'(n_start - base), 32'd3);
        check_op("t3 bksp a0", base,     8'h8F, 1'b0);
        check_op("t3 bksp sp", base + 1, 8'h20, 1'b1);
        check_op("t3 bksp a1", base + 2, 8'h8F, 1'b0);
        check_cursor("t3 bksp", 1'b0, 4'd15);

        // 4: backspace at (0,3), then at (0,0)
        push(8'h2A);
        for (int i = 0; i < 3; i++) push(8'h41);
        wait_idle("t4a");
        check_cursor("t4 pre", 1'b0, 4'd3);
        base = n_start;
        push(8'h23);
        wait_idle("t4b");
        check("t4 op count", 32'(n_start - base), 32'd3);
        check_op("t4 a0", base,     8'h82, 1'b0);
        check_op("t4 sp", base + 1, 8'h20, 1'b1);
        check_op("t4 a1", base + 2, 8'h82, 1'b0);
        check_cursor("t4", 1'b0, 4'd2);
        push(8'h2A);
        wait_idle("t4c");
        base = n_start; rd0 = n_rd;
        push(8'h23);
        wait_idle("t4d");
        check("t4 home bksp ops", 32'(n_start - base), 32'd0);
        check("t4 home bksp rd", 32'(n_rd - rd0), 32'd1);
        check_cursor("t4 home", 1'b0, 4'd0);

        // last-line wrap back to line 0
        for (int i = 0; i < 32; i++) push(8'h31);
        wait_idle("t4e");
        check_op("t4 wrap0 addr", n_start - 1, 8'h80, 1'b0);
        check_cursor("t4 wrap0", 1'b0, 4'd0);

        // 5: clear at (1,5), then an unprintable key
        for (int i = 0; i < 21; i++) push(8'h42);
        wait_idle("t5a");
        check_cursor("t5 pre", 1'b1, 4'd5);
        base = n_start;
        push(8'h2A);
        wait_idle("t5b");
        check("t5 clear count", 32'(n_start - base), 32'd1);
        check_op("t5 clear", base, 8'h01, 1'b0);
        check_cursor("t5", 1'b0, 4'd0);
        base = n_start; rd0 = n_rd;
        push(8'h0D);
        wait_idle("t5c");
        check("t5 junk rd", 32'(n_rd - rd0), 32'd1);
        check("t5 junk ops", 32'(n_start - base), 32'd0);
        check("t5 busy", 32'(busy), 32'd0);

        // 6: reset in WAIT_HI of a backspace, keys queued, init replays first
        push(8'h41);
        push(8'h41);
        wait_idle("t6a");
        base = n_start;
        push(8'h23);
        t = 0;
        while (n_start < base + 2 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("t6 reached op2", 32'(n_start - base), 32'd2);
        repeat (2) @(negedge clk);
        push(8'h41);
        push(8'h41);
        rst = 1'b0;
        #1;
        check("t6 reset outs", 32'({fifo_rd_en, lcd_start, lcd_data, lcd_rs, init_done,
                                    busy, cursor_row, cursor_col}), 32'd0);
        repeat (3) @(negedge clk);
        base = n_start; rd0 = n_rd;
        rst = 1'b1;
        wait_init("t6");
        check("t6 rd before init", 32'(n_rd - rd0), 32'd0);
        check_init("t6", base);
        wait_idle("t6b");
        check("t6 queued rd", 32'(n_rd - rd0), 32'd2);
        check_cursor("t6", 1'b0, 4'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
